// File: rtl/debug_mux_pkg.sv
// Shared types for the debug-mux scan sequencer: FSM state encoding and
// the settle-counter type (wide enough for SETTLE_CYC up to 255).
package debug_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BASE   = 3'd1,
    ST_APPLY  = 3'd2,
    ST_REPORT = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  localparam int SETTLE_W = 8;

  typedef logic [SETTLE_W-1:0] settle_t;

endpackage

// File: rtl/debug_mux_prio_find.sv
// Priority search for the next enabled mux index. With i_from_start set the
// lowest enabled index is returned; otherwise the lowest enabled index
// strictly above i_cur_idx. Purely combinational so skipped indices cost
// no cycles in the sequencer.
module debug_mux_prio_find #(
  parameter int NUM_SEL = 8,
  parameter int IDX_W   = $clog2(NUM_SEL)
) (
  input  logic [NUM_SEL-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_cur_idx,
  input  logic               i_from_start,
  output logic [IDX_W-1:0]   o_next_idx,
  output logic               o_found
);

  logic w_hit;

  // Scan from the top down so the lowest qualifying index is the last writer.
  always_comb begin
    o_next_idx = '0;
    o_found    = 1'b0;
    w_hit      = 1'b0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      w_hit      = i_mask[i] && (i_from_start || (i > int'(i_cur_idx)));
      o_found    = o_found | w_hit;
      o_next_idx = w_hit ? IDX_W'(i) : o_next_idx;
    end
  end

endmodule

// File: rtl/debug_mux_sequencer.sv
// Debug-mux scan sequencer: captures a baseline with all selects off, then
// walks every enabled mux index, forces a value through it, captures the
// observed outputs and reports each result over a valid/ready handshake.
// All outputs are registered from next-state values so they line up with
// the state they describe.
module debug_mux_sequencer
  import debug_mux_pkg::*;
#(
  parameter int NUM_SEL    = 8,
  parameter int DATA_W     = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_SEL-1:0]         cfg_sel_mask,
  input  logic [DATA_W-1:0]          cfg_force_val,
  output logic [NUM_SEL-1:0]         mux_sel,
  output logic [DATA_W-1:0]          mux_force,
  input  logic [DATA_W-1:0]          obs_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_SEL)-1:0] res_idx,
  output logic [DATA_W-1:0]          res_data,
  output logic                       res_mismatch,
  output logic                       busy,
  output logic                       done
);

  localparam int                 IDX_W       = $clog2(NUM_SEL);
  localparam settle_t            SETTLE_LOAD = settle_t'(SETTLE_CYC - 1);
  localparam logic [NUM_SEL-1:0] SEL_LSB     = {{(NUM_SEL-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  settle_t             r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [NUM_SEL-1:0]  r_mask, w_mask_nxt;
  logic [DATA_W-1:0]   r_fval, w_fval_nxt;
  logic [DATA_W-1:0]   r_baseline, w_baseline_nxt;
  logic [NUM_SEL-1:0]  r_mux_sel, w_mux_sel_nxt;
  logic [DATA_W-1:0]   r_mux_force, w_mux_force_nxt;
  logic [IDX_W-1:0]    r_res_idx, w_res_idx_nxt;
  logic [DATA_W-1:0]   r_res_data, w_res_data_nxt;
  logic                r_res_mismatch, w_res_mismatch_nxt;
  logic                r_res_valid, r_busy, r_done;
  logic                w_drive_sel;
  logic [IDX_W-1:0]    w_find_idx;
  logic                w_find_ok;
  logic                w_from_start;

  // The first search after the baseline starts at index 0 inclusive.
  assign w_from_start = (r_state == ST_BASE);

  debug_mux_prio_find #(
    .NUM_SEL (NUM_SEL),
    .IDX_W   (IDX_W)
  ) u_prio_find (
    .i_mask       (r_mask),
    .i_cur_idx    (r_idx),
    .i_from_start (w_from_start),
    .o_next_idx   (w_find_idx),
    .o_found      (w_find_ok)
  );

  // Next-state, datapath updates and next output values.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_idx_nxt          = r_idx;
    w_mask_nxt         = r_mask;
    w_fval_nxt         = r_fval;
    w_baseline_nxt     = r_baseline;
    w_res_idx_nxt      = r_res_idx;
    w_res_data_nxt     = r_res_data;
    w_res_mismatch_nxt = r_res_mismatch;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_BASE;
          w_mask_nxt  = cfg_sel_mask;
          w_fval_nxt  = cfg_force_val;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BASE: begin
        if (r_cnt == '0) begin
          w_baseline_nxt = obs_in;
          w_cnt_nxt      = SETTLE_LOAD;
          w_idx_nxt      = w_find_idx;
          w_state_nxt    = w_find_ok ? ST_APPLY : ST_FIN;
        end else begin
          w_cnt_nxt = r_cnt - settle_t'(1);
        end
      end
      ST_APPLY: begin
        if (r_cnt == '0) begin
          w_res_idx_nxt      = r_idx;
          w_res_data_nxt     = obs_in;
          w_res_mismatch_nxt = (obs_in != r_baseline);
          w_state_nxt        = ST_REPORT;
        end else begin
          w_cnt_nxt = r_cnt - settle_t'(1);
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          w_cnt_nxt   = SETTLE_LOAD;
          w_idx_nxt   = w_find_ok ? w_find_idx : r_idx;
          w_state_nxt = w_find_ok ? ST_APPLY : ST_FIN;
        end else begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_drive_sel     = (w_state_nxt == ST_APPLY) || (w_state_nxt == ST_REPORT);
    w_mux_sel_nxt   = w_drive_sel ? (SEL_LSB << w_idx_nxt) : '0;
    w_mux_force_nxt = w_drive_sel ? w_fval_nxt : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs; reset drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_idx          <= '0;
      r_mask         <= '0;
      r_fval         <= '0;
      r_baseline     <= '0;
      r_mux_sel      <= '0;
      r_mux_force    <= '0;
      r_res_idx      <= '0;
      r_res_data     <= '0;
      r_res_mismatch <= 1'b0;
      r_res_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_mask         <= w_mask_nxt;
      r_fval         <= w_fval_nxt;
      r_baseline     <= w_baseline_nxt;
      r_mux_sel      <= w_mux_sel_nxt;
      r_mux_force    <= w_mux_force_nxt;
      r_res_idx      <= w_res_idx_nxt;
      r_res_data     <= w_res_data_nxt;
      r_res_mismatch <= w_res_mismatch_nxt;
      r_res_valid    <= (w_state_nxt == ST_REPORT);
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_done         <= (w_state_nxt == ST_FIN);
    end
  end

  assign mux_sel      = r_mux_sel;
  assign mux_force    = r_mux_force;
  assign res_valid    = r_res_valid;
  assign res_idx      = r_res_idx;
  assign res_data     = r_res_data;
  assign res_mismatch = r_res_mismatch;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_debug_mux_sequencer.sv
// Self-checking bench for debug_mux_sequencer (NUM_SEL=4, DATA_W=4,
// SETTLE_CYC=2). A scan is modelled as the ordered list of enabled indices,
// each expected to report the environment's observed value for that index,
// with the scan length derived from the per-index cycle cost plus stalls.
module tb_debug_mux_sequencer;

  localparam int NS = 4;
  localparam int DW = 4;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NS-1:0] cfg_sel_mask;
  logic [DW-1:0] cfg_force_val;
  logic [NS-1:0] mux_sel;
  logic [DW-1:0] mux_force;
  logic [DW-1:0] obs_in;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_idx;
  logic [DW-1:0] res_data;
  logic          res_mismatch;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] obs_base;
  logic [DW-1:0] obs_tab [NS];

  debug_mux_sequencer #(
    .NUM_SEL    (NS),
    .DATA_W     (DW),
    .SETTLE_CYC (SC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_sel_mask  (cfg_sel_mask),
    .cfg_force_val (cfg_force_val),
    .mux_sel       (mux_sel),
    .mux_force     (mux_force),
    .obs_in        (obs_in),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_idx       (res_idx),
    .res_data      (res_data),
    .res_mismatch  (res_mismatch),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Environment: the observed bus shows the baseline value unless exactly
  // one mux is selected, in which case it shows that mux's table entry.
  always_comb begin
    obs_in = obs_base;
    for (int i = 0; i < NS; i++) begin
      if (mux_sel == (4'b0001 << i)) obs_in = obs_tab[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one scan from IDLE (called at a falling edge) and check it.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] f,
                          input int ready_pct, input int stall_first, input bit poke_start);
    int         exp_idx[$];
    logic [3:0] exp_dat[$];
    logic       exp_mis[$];
    int         stalls, nres, hold_left, exp_n;
    bit         seen_done, first_rep;
    logic [3:0] s_sel, s_force, s_data;
    logic [1:0] s_idx;
    logic       s_mis;
    for (int i = 0; i < NS; i++) begin
      if (m[i]) begin
        exp_idx.push_back(i);
        exp_dat.push_back(obs_tab[i]);
        exp_mis.push_back(obs_tab[i] != obs_base);
      end
    end
    stalls = 0; nres = 0; hold_left = 0; seen_done = 1'b0; first_rep = 1'b0;
    s_sel = '0; s_force = '0; s_data = '0; s_idx = '0; s_mis = 1'b0;
    cfg_sel_mask  = m;
    cfg_force_val = f;
    start         = 1'b1;
    res_ready     = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      @(negedge clk);
      cfg_sel_mask  = 4'($urandom);
      cfg_force_val = 4'($urandom);
      start         = ($urandom_range(0, 3) == 0);
      chk("busy_in_scan", busy, 1);
      chk("sel_onehot", 32'($countones(mux_sel) <= 1), 1);
      chk("done_with_valid", done & res_valid, 0);
      chk("force_value", mux_force, (mux_sel == 4'd0) ? 4'd0 : f);
      res_ready = ($urandom_range(0, 99) < ready_pct);
      if (res_valid) begin
        if (nres < exp_idx.size()) begin
          chk("res_idx", res_idx, exp_idx[nres]);
          chk("res_data", res_data, exp_dat[nres]);
          chk("res_mismatch", res_mismatch, exp_mis[nres]);
          chk("sel_in_report", mux_sel, 4'b0001 << exp_idx[nres]);
        end else begin
          chk("extra_result", 1, 0);
        end
        if (!first_rep) begin
          first_rep = 1'b1;
          hold_left = stall_first;
          s_sel = mux_sel; s_force = mux_force; s_idx = res_idx;
          s_data = res_data; s_mis = res_mismatch;
          if (poke_start) start = 1'b1;
        end else if (hold_left > 0) begin
          chk("frozen_sel", mux_sel, s_sel);
          chk("frozen_force", mux_force, s_force);
          chk("frozen_idx", res_idx, s_idx);
          chk("frozen_data", res_data, s_data);
          chk("frozen_mis", res_mismatch, s_mis);
        end
        if (hold_left > 0) begin
          res_ready = 1'b0;
          hold_left--;
        end
        if (res_ready) nres++;
        else stalls++;
      end
      if (done) begin
        seen_done = 1'b1;
        start     = 1'b0;
        exp_n     = SC + exp_idx.size() * (SC + 1) + stalls;
        chk("done_cycle", cyc, exp_n);
        chk("result_count", nres, exp_idx.size());
        chk("sel_at_fin", mux_sel, 0);
      end
    end
    if (!seen_done) chk("scan_timeout", 0, 1);
    start     = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("idle_valid", res_valid, 0);
    chk("idle_sel", mux_sel, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    cfg_sel_mask = '0; cfg_force_val = '0; obs_base = '0;
    for (int i = 0; i < NS; i++) obs_tab[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel", mux_sel, 0);
    chk("rst_force", mux_force, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_data", res_data, 0);
    chk("rst_mis", res_mismatch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Sparse mask: idx0 sees a changed value, idx2 sees the baseline.
    obs_base = 4'h3;
    obs_tab[0] = 4'hC; obs_tab[1] = 4'h7; obs_tab[2] = 4'h3; obs_tab[3] = 4'h1;
    run_scan(4'b0101, 4'hA, 100, 0, 1'b0);

    // Empty mask: baseline then straight to completion.
    run_scan(4'b0000, 4'h5, 100, 0, 1'b0);

    // Full mask with a 10-cycle stall in the first report.
    obs_tab[0] = 4'h9; obs_tab[1] = 4'h3; obs_tab[2] = 4'hE; obs_tab[3] = 4'h0;
    run_scan(4'b1111, 4'h6, 100, 10, 1'b0);

    // Start pulsed during a report must not disturb the scan.
    run_scan(4'b1010, 4'h9, 100, 0, 1'b1);

    // Asynchronous reset while applying index 1, then a full fresh scan.
    cfg_sel_mask = 4'hF; cfg_force_val = 4'h7; start = 1'b1; res_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mux_sel == 4'b0010) found = 1'b1;
    end
    chk("reach_apply_idx1", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", mux_sel, 0);
    chk("async_rst_force", mux_force, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    run_scan(4'b1111, 4'h3, 100, 0, 1'b0);

    // Randomised scans with random backpressure.
    for (int t = 0; t < 20; t++) begin
      obs_base = 4'($urandom);
      for (int i = 0; i < NS; i++) obs_tab[i] = ($urandom_range(0, 2) == 0) ? obs_base : 4'($urandom);
      run_scan(4'($urandom), 4'($urandom), 60, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
